// File: rtl/vmem_fill_ctrl_pkg.sv
// vmem_fill_ctrl shared definitions
// screen geometry, register offsets, FSM states, clip helper
package vmem_fill_ctrl_pkg;

    localparam int SCREEN_W = 240;
    localparam int SCREEN_H = 240;
    localparam int ADDR_W   = 16;
    localparam int PIX_W    = 3;

    localparam logic [1:0] FILL_ORIGIN = 2'd0;
    localparam logic [1:0] FILL_SIZE   = 2'd1;
    localparam logic [1:0] FILL_COLOR  = 2'd2;
    localparam logic [1:0] FILL_ABORT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } fill_state_e;

    // Extent of a span clipped to the screen edge; caller
    // must separately reject org >= lim.
    function automatic logic [8:0] clip_extent(
        input logic [7:0] org,
        input logic [7:0] len,
        input logic [8:0] lim
    );
        logic [8:0] room;
        room = lim - {1'b0, org};
        return ({1'b0, len} < room) ? {1'b0, len} : room;
    endfunction

endpackage

// File: rtl/vmem_fill_ctrl_if.sv
// vmem write port bundle
// master drives the single vmem write port, slave is the memory
interface vmem_fill_ctrl_if;
    import vmem_fill_ctrl_pkg::*;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [PIX_W-1:0]  wdata;

    modport master (output we, waddr, wdata);
    modport slave  (input  we, waddr, wdata);

endinterface

// File: rtl/vmem_fill_cursor.sv
// raster cursor for the fill engine
// clips the rectangle at load, walks x then y, flags last pixel
module vmem_fill_cursor
    import vmem_fill_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       adv_i,
    input  logic [7:0] x0_i,
    input  logic [7:0] y0_i,
    input  logic [7:0] w_i,
    input  logic [7:0] h_i,
    output logic       empty_o,
    output logic       last_o,
    output logic [7:0] cx_o,
    output logic [7:0] cy_o
);

    logic [8:0] ew;
    logic [8:0] eh;
    logic [8:0] xs;
    logic [8:0] xe;
    logic [8:0] ye;
    logic [8:0] cx;
    logic [8:0] cy;

    // clipped extents and zero-area detection for the pending start
    always_comb begin
        ew = clip_extent(x0_i, w_i, 9'(SCREEN_W));
        eh = clip_extent(y0_i, h_i, 9'(SCREEN_H));
        empty_o = ({1'b0, x0_i} >= 9'(SCREEN_W))
               || ({1'b0, y0_i} >= 9'(SCREEN_H))
               || (w_i == 8'd0)
               || (h_i == 8'd0);
    end

    // latch bounds on load, step the cursor on each engine write
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            xs <= '0;
            xe <= '0;
            ye <= '0;
            cx <= '0;
            cy <= '0;
        end else if (load_i) begin
            xs <= {1'b0, x0_i};
            xe <= {1'b0, x0_i} + ew - 9'd1;
            ye <= {1'b0, y0_i} + eh - 9'd1;
            cx <= {1'b0, x0_i};
            cy <= {1'b0, y0_i};
        end else if (adv_i) begin
            if (cx == xe) begin
                cx <= xs;
                cy <= cy + 9'd1;
            end else begin
                cx <= cx + 9'd1;
            end
        end
    end

    assign last_o = (cx == xe) && (cy == ye);
    assign cx_o   = cx[7:0];
    assign cy_o   = cy[7:0];

endmodule

// File: rtl/vmem_fill_ctrl.sv
// rectangle fill engine and vmem write-port arbiter
// CPU stores win the port; the engine retries on the next free cycle
module vmem_fill_ctrl
    import vmem_fill_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [PIX_W-1:0]  cpu_wdata_i,
    input  logic              cfg_we_i,
    input  logic [1:0]        cfg_sel_i,
    input  logic [31:0]       cfg_wdata_i,
    vmem_fill_ctrl_if.master  vmem,
    output logic              busy_o,
    output logic              done_o
);

    fill_state_e state_q;
    fill_state_e state_d;

    logic [15:0]      origin_q;
    logic [15:0]      size_q;
    logic [PIX_W-1:0] color_q;
    logic [PIX_W-1:0] run_color_q;
    logic             done_q;
    logic             done_d;

    logic start;
    logic abort;
    logic load;
    logic adv;
    logic eng_we;
    logic empty;
    logic last;
    logic [7:0] cx;
    logic [7:0] cy;

    logic unused_cfg_hi;
    assign unused_cfg_hi = ^cfg_wdata_i[31:16];

    assign start = cfg_we_i && (cfg_sel_i == FILL_COLOR)
                && (state_q == ST_IDLE);
    assign abort = cfg_we_i && (cfg_sel_i == FILL_ABORT);

    vmem_fill_cursor u_cursor (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (load),
        .adv_i   (adv),
        .x0_i    (origin_q[7:0]),
        .y0_i    (origin_q[15:8]),
        .w_i     (size_q[7:0]),
        .h_i     (size_q[15:8]),
        .empty_o (empty),
        .last_o  (last),
        .cx_o    (cx),
        .cy_o    (cy)
    );

    // config registers; the running fill keeps its own colour copy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            origin_q    <= '0;
            size_q      <= '0;
            color_q     <= '0;
            run_color_q <= '0;
        end else begin
            if (cfg_we_i) begin
                unique case (cfg_sel_i)
                    FILL_ORIGIN: origin_q <= cfg_wdata_i[15:0];
                    FILL_SIZE:   size_q   <= cfg_wdata_i[15:0];
                    FILL_COLOR:  color_q  <= cfg_wdata_i[PIX_W-1:0];
                    default:     ;
                endcase
            end
            if (start) begin
                run_color_q <= cfg_wdata_i[PIX_W-1:0];
            end
        end
    end

    // FSM state and registered done pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // next state, cursor control and engine write request
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        eng_we  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = empty ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!cpu_we_i) begin
                    eng_we = 1'b1;
                    adv    = 1'b1;
                    if (last) begin
                        state_d = ST_DONE;
                    end
                end
                if (abort) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // registered write port, CPU store has priority
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vmem.we    <= 1'b0;
            vmem.waddr <= '0;
            vmem.wdata <= '0;
        end else begin
            vmem.we <= cpu_we_i | eng_we;
            if (cpu_we_i) begin
                vmem.waddr <= cpu_addr_i;
                vmem.wdata <= cpu_wdata_i;
            end else if (eng_we) begin
                vmem.waddr <= {cy, cx};
                vmem.wdata <= run_color_q;
            end
        end
    end

    assign busy_o = (state_q == ST_RUN);
    assign done_o = done_q;

    logic unused_color;
    assign unused_color = ^color_q;

endmodule
